t_ff_counter: RTL

- Parametrised synchronous up/down counter built from a bank of WIDTH toggle flip-flops. It is the successor of the single-bit T flip-flop.
- Each bit's toggle input is derived from the lower-bit carry/borrow chain.
- Adds modulus wrap, parallel load, synchronous preset/clear, direction control and a terminal-count flag.
- Used as a generic event/divider counter in the datapath labs.

---
 rtl/t_ff_pkg.sv | 15 +
 rtl/t_ff_cell.sv | 28 ++
 rtl/t_ff_counter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/t_ff_pkg.sv
// Shared definitions for the toggle-flip-flop based counter.
// Provides the terminal-value helper and the direction encoding.
package t_ff_pkg;

    // Direction encoding on the 'up' input.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Largest legal count for a given modulus.
    // The caller truncates the result to WIDTH bits.
    function automatic int cnt_max(input int modulus);
        return modulus - 32'sd1;
    endfunction

endpackage : t_ff_pkg

// File: rtl/t_ff_cell.sv
// Single T flip-flop with synchronous clear, set and direct load.
// Input priority: clr > set > ld > t.
module t_ff_cell (
    input  logic clk,
    input  logic clr,
    input  logic set,
    input  logic ld,
    input  logic ld_val,
    input  logic t,
    output logic q
);

    // State update: clear, set, load, toggle, otherwise hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else if (ld) begin
            q <= ld_val;
        end else if (t) begin
            q <= ~q;
        end else begin
            q <= q;
        end
    end

endmodule : t_ff_cell

// File: rtl/t_ff_counter.sv
// Modulo-MOD up/down counter built from WIDTH T flip-flops.
// Each bit toggles from the lower-bit carry/borrow chain. Wrap, clamp and
// preset are applied as direct loads of the cells.
// Optional macro T_FF_COUNTER_SAT_EN: saturate at the ends of the range
// instead of wrapping around.
module t_ff_counter
    import t_ff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             pre,
    input  logic             load,
    input  logic             en,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] p,
    output logic             tc
);

    // Elaboration-time legality checks on the parameters.
    if (WIDTH < 1) begin : g_bad_width
        $error("t_ff_counter: WIDTH must be at least 1");
    end
    if ((MOD < 2) || (MOD > (2 ** WIDTH))) begin : g_bad_mod
        $error("t_ff_counter: MOD must lie in 2..2**WIDTH");
    end

    localparam int             CNT_MAX_I = cnt_max(MOD);
    localparam logic [WIDTH-1:0] CNT_MAX = CNT_MAX_I[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ALL_ONE  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] clr_vec_s;
    logic [WIDTH-1:0] set_vec_s;
    logic [WIDTH-1:0] ld_vec_s;
    logic [WIDTH-1:0] ld_val_s;
    logic [WIDTH-1:0] tog_vec_s;
    logic             at_max_s;
    logic             at_zero_s;
    logic             term_s;

    // Terminal detection at WIDTH bits for the current direction.
    always_comb begin
        at_max_s  = (q == CNT_MAX);
        at_zero_s = (q == ALL_ZERO);
        if (up == DIR_UP) begin
            term_s = at_max_s;
        end else begin
            term_s = at_zero_s;
        end
    end

    // Toggle chain: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic lo_ones;
        logic lo_zeros;
        tog_vec_s = ALL_ZERO;
        lo_ones   = 1'b1;
        lo_zeros  = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (up == DIR_UP) begin
                tog_vec_s[i] = en & lo_ones;
            end else begin
                tog_vec_s[i] = en & lo_zeros;
            end
            lo_ones  = lo_ones & q[i];
            lo_zeros = lo_zeros & ~q[i];
        end
    end

    // Direct-control vectors: clear, preset pattern, load/clamp, wrap/saturate.
    always_comb begin
        clr_vec_s = ALL_ZERO;
        set_vec_s = ALL_ZERO;
        ld_vec_s  = ALL_ZERO;
        ld_val_s  = ALL_ZERO;
        if (clr) begin
            clr_vec_s = ALL_ONE;
        end else if (pre) begin
            // Preset drives each cell to the matching bit of MOD-1.
            set_vec_s = CNT_MAX;
            clr_vec_s = ~CNT_MAX;
        end else if (load) begin
            ld_vec_s = ALL_ONE;
            if (d > CNT_MAX) begin
                ld_val_s = CNT_MAX;
            end else begin
                ld_val_s = d;
            end
        end else if (en && term_s) begin
            ld_vec_s = ALL_ONE;
`ifdef T_FF_COUNTER_SAT_EN
            // Saturate: reload the current value so the toggles are masked.
            ld_val_s = q;
`else
            // Wrap: up past MOD-1 returns to 0, down past 0 goes to MOD-1.
            if (up == DIR_UP) begin
                ld_val_s = ALL_ZERO;
            end else begin
                ld_val_s = CNT_MAX;
            end
`endif
        end else begin
            // Plain counting or hold: the toggle chain alone drives the cells.
            ld_vec_s = ALL_ZERO;
        end
    end

    // Terminal-count flag and complement output.
    always_comb begin
        tc = en & ~clr & ~pre & ~load & term_s;
        p  = ~q;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .clk    (clk),
            .clr    (clr_vec_s[i]),
            .set    (set_vec_s[i]),
            .ld     (ld_vec_s[i]),
            .ld_val (ld_val_s[i]),
            .t      (tog_vec_s[i]),
            .q      (q[i])
        );
    end

endmodule : t_ff_counter
